csa_resolver: RTL and testbench
===============================

CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each carry-save input vector; the block SHALL reject WIDTH < 2 at elaboration.
REQ-002 Parameter CHUNK, default 8, bits resolved per cycle; the block SHALL reject CHUNK < 1 or WIDTH mod CHUNK != 0 at elaboration.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 nreset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  carry-save operand pair present.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 in_sum  input  WIDTH  carry-save sum vector S (full-adder Y outputs).
REQ-008 in_carry  input  WIDTH  carry-save carry vector C (full-adder X outputs), weight 2 relative to S.
REQ-009 out_valid  output  1  resolved result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out_result  output  WIDTH+2  binary value S + 2*C, full precision.

Function
REQ-012 The block SHALL implement a state machine with states IDLE, RUN, DONE.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid=1, it SHALL capture S and {C[WIDTH-2:0],1'b0} into operand registers, clear chunk counter and carry register, and enter RUN.
REQ-014 RUN: in_ready=0, out_valid=0; each cycle it SHALL add operand chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) plus the carry register, write the CHUNK sum bits into out_result at the same position, store carry-out, increment k.
REQ-015 On the last chunk (k = WIDTH/CHUNK-1), it SHALL write out_result[WIDTH+1:WIDTH] = C[WIDTH-1] + final carry-out (2-bit add) and enter DONE.
REQ-016 Latency SHALL be exactly WIDTH/CHUNK cycles from the accept edge to out_valid=1.
REQ-017 DONE: out_valid=1, in_ready=0; out_result SHALL hold stable until out_valid&&out_ready, after which the state SHALL be IDLE on the next cycle.
REQ-018 in_valid during RUN or DONE SHALL be ignored; no input is lost because in_ready=0.
REQ-019 Throughput SHALL be one result per WIDTH/CHUNK+2 cycles with out_ready held high.
REQ-020 WIDTH/CHUNK = 1 SHALL work: RUN lasts one cycle.
REQ-021 The counter SHALL be ceil(log2(WIDTH/CHUNK+1)) bits and SHALL never wrap within an operation.

Reset
REQ-022 nreset low SHALL asynchronously force IDLE, in_ready=1, out_valid=0, out_result=0, counter=0, carry=0, operands=0.
REQ-023 Reset during RUN or DONE SHALL abandon the operation; no partial result is ever presented.
REQ-024 Release of nreset SHALL take effect on the next rising clk; the first accept is possible on that edge.

Structure
REQ-025 Package csa_pkg SHALL hold the state enum typedef (IDLE, RUN, DONE) and the chunk-count localparam function.
REQ-026 Sub-module csa_chunk_adder SHALL be a purely combinational CHUNK-bit ripple of per-bit full adders (A, B, CI -> S, CO), written so synthesis infers $fa cells for techmapping onto FA_X1/HA_X1.
REQ-027 All sequential state SHALL reside in csa_resolver; csa_chunk_adder SHALL be instantiated exactly once.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-028 S=0xFF, C=0xFF accepted -> out_valid exactly 2 cycles later, out_result=0x2FD.
REQ-029 S=0x00, C=0x80 -> out_result=0x100; S=0x0F, C=0x00 -> out_result=0x00F.
REQ-030 S=0x55, C=0x55 with out_ready=0 for 5 cycles -> out_result=0x0FF held stable, in_ready=0 throughout, in_valid pulses ignored.
REQ-031 nreset asserted in RUN after 1 chunk -> immediate IDLE, out_valid=0, out_result=0; next operand S=0x01,C=0x01 -> 0x003.
REQ-032 Back-to-back with out_ready=1, 100 random pairs, WIDTH=32, CHUNK=8 and CHUNK=32 -> every result equals S+2*C, spacing WIDTH/CHUNK+2 cycles.

Source files
------------

// File: rtl/csa_pkg.sv
// csa_pkg: state encoding and sizing helpers shared by the carry-save resolver
package csa_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Number of CHUNK-wide slices in a WIDTH-wide operand; guarded so a bad
  // CHUNK still elaborates far enough to reach the parameter checks.
  function automatic int chunk_count(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  // Counter width that can hold every value 0..chunks without wrapping.
  function automatic int count_width(input int chunks);
    return (chunks < 1) ? 1 : $clog2(chunks + 1);
  endfunction

endpackage

// File: rtl/csa_chunk_adder.sv
// csa_chunk_adder: combinational CHUNK-bit ripple of per-bit full adders
module csa_chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic c;

  // Each iteration is one full adder; the running carry ripples bit to bit.
  always_comb begin
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair S,C into binary S + 2*C, CHUNK bits per cycle
module csa_resolver
  import csa_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result
);

  localparam int N  = chunk_count(WIDTH, CHUNK);
  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [WIDTH+1:0] MASK = {{(WIDTH + 2 - CHUNK){1'b0}}, {CHUNK{1'b1}}};

  if (WIDTH < 2) begin : g_bad_width
    $error("csa_resolver: WIDTH must be at least 2");
  end

  if (CHUNK < 1) begin : g_bad_chunk
    $error("csa_resolver: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_split
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] op_s;
  logic [WIDTH-1:0] op_c;
  logic             c_msb;
  int               shamt;
  logic [CHUNK-1:0] a_k;
  logic [CHUNK-1:0] b_k;
  logic [CHUNK-1:0] sum_k;
  logic             co_k;
  logic             last;
  logic [WIDTH+1:0] merged;

  // Slice the current chunk out of both operands and splice its sum back in place.
  always_comb begin
    shamt  = int'(cnt) * CHUNK;
    a_k    = CHUNK'(op_s >> shamt);
    b_k    = CHUNK'(op_c >> shamt);
    last   = cnt == LAST;
    merged = (out_result & ~(MASK << shamt)) | ((WIDTH + 2)'(sum_k) << shamt);
  end

  csa_chunk_adder #(.CHUNK(CHUNK)) u_adder (
    .a (a_k),
    .b (b_k),
    .ci(carry),
    .s (sum_k),
    .co(co_k)
  );

  // IDLE/RUN/DONE control with registered handshake outputs and datapath state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      op_s       <= '0;
      op_c       <= '0;
      c_msb      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_s       <= in_sum;
          op_c       <= {in_carry[WIDTH-2:0], 1'b0};
          c_msb      <= in_carry[WIDTH-1];
          cnt        <= '0;
          carry      <= 1'b0;
          out_result <= '0;
          in_ready   <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          carry      <= co_k;
          cnt        <= cnt + CW'(1);
          out_result <= last ? {{1'b0, c_msb} + {1'b0, co_k}, merged[WIDTH-1:0]} : merged;
          if (last) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed checks of csa_resolver at 8/4, 32/8 and 32/32
module tb_csa_resolver;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  logic       iv8 = 1'b0, or8 = 1'b1, ir8, ov8;
  logic [7:0] s8 = '0, c8 = '0;
  logic [9:0] r8;

  logic        iva = 1'b0, ivb = 1'b0, or32 = 1'b1, ira, irb, ova, ovb;
  logic [31:0] s32 = '0, c32 = '0;
  logic [33:0] ra, rb;

  int checks = 0;
  int errors = 0;

  csa_resolver #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .nreset(nreset), .in_valid(iv8), .in_ready(ir8), .in_sum(s8), .in_carry(c8),
    .out_valid(ov8), .out_ready(or8), .out_result(r8)
  );

  csa_resolver #(.WIDTH(32), .CHUNK(8)) dut_a (
    .clk(clk), .nreset(nreset), .in_valid(iva), .in_ready(ira), .in_sum(s32), .in_carry(c32),
    .out_valid(ova), .out_ready(or32), .out_result(ra)
  );

  csa_resolver #(.WIDTH(32), .CHUNK(32)) dut_b (
    .clk(clk), .nreset(nreset), .in_valid(ivb), .in_ready(irb), .in_sum(s32), .in_carry(c32),
    .out_valid(ovb), .out_ready(or32), .out_result(rb)
  );

  // Called at a negedge with dut8 idle and or8 high; accepts on the next posedge.
  task automatic run8(input logic [7:0] s, input logic [7:0] c, input logic [9:0] exp, input string nm);
    int lat;
    iv8 = 1'b1;
    s8  = s;
    c8  = c;
    @(negedge clk);
    iv8 = 1'b0;
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles expected 2", nm, lat);
    end
    checks++;
    if (r8 !== exp) begin
      errors++;
      $display("FAIL %s result: got %h expected %h", nm, r8, exp);
    end
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got ir=%b ov=%b expected ir=1 ov=0", nm, ir8, ov8);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || r8 !== 10'h000) begin
      errors++;
      $display("FAIL reset8: got ir=%b ov=%b res=%h expected ir=1 ov=0 res=000", ir8, ov8, r8);
    end
    checks++;
    if (ira !== 1'b1 || ova !== 1'b0 || ra !== 34'h0 || irb !== 1'b1 || ovb !== 1'b0 || rb !== 34'h0) begin
      errors++;
      $display("FAIL reset32: got ira=%b ova=%b ra=%h irb=%b ovb=%b rb=%h expected 1 0 0 1 0 0",
               ira, ova, ra, irb, ovb, rb);
    end
    nreset = 1'b1;
  endtask

  task automatic test_basic();
    run8(8'hFF, 8'hFF, 10'h2FD, "ff_ff");
    run8(8'h00, 8'h80, 10'h100, "c_msb_only");
    run8(8'h0F, 8'h00, 10'h00F, "s_only");
    run8(8'h00, 8'h00, 10'h000, "zero");
    run8(8'h00, 8'hFF, 10'h1FE, "c_only");
    run8(8'h80, 8'h40, 10'h100, "chunk_carry");
  endtask

  task automatic test_hold();
    int lat;
    or8 = 1'b0;
    iv8 = 1'b1;
    s8  = 8'h55;
    c8  = 8'h55;
    @(negedge clk);
    lat = 0;
    while (!ov8 && lat < 20) begin
      iv8 = 1'b1;
      s8  = 8'hA0;
      c8  = 8'h0A;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL hold latency: got %0d cycles expected 2", lat);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (r8 !== 10'h0FF || ir8 !== 1'b0 || ov8 !== 1'b1) begin
        errors++;
        $display("FAIL hold cycle %0d: got res=%h ir=%b ov=%b expected res=0ff ir=0 ov=1", i, r8, ir8, ov8);
      end
      iv8 = i[0];
      s8  = 8'(i * 37);
      c8  = ~s8;
      @(negedge clk);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    @(negedge clk);
    checks++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL hold release: got ir=%b ov=%b expected ir=1 ov=0", ir8, ov8);
    end
  endtask

  task automatic test_reset_mid();
    iv8 = 1'b1;
    s8  = 8'hAA;
    c8  = 8'h33;
    @(negedge clk);
    iv8 = 1'b0;
    @(negedge clk);
    nreset = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1 || r8 !== 10'h000) begin
      errors++;
      $display("FAIL reset_mid: got ov=%b ir=%b res=%h expected ov=0 ir=1 res=000", ov8, ir8, r8);
    end
    @(negedge clk);
    nreset = 1'b1;
    run8(8'h01, 8'h01, 10'h003, "after_reset");
  endtask

  task automatic test_back_to_back(input bit which);
    logic [33:0] q[$];
    logic [33:0] exp;
    logic        ir, ov;
    logic [33:0] r;
    int sent = 0, got = 0, cyc = 0, last_ov = -1;
    int space = which ? 3 : 6;
    or32 = 1'b1;
    while (got < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      ir = which ? irb : ira;
      ov = which ? ovb : ova;
      r  = which ? rb : ra;
      if (ov) begin
        exp = (q.size() > 0) ? q.pop_front() : 34'h3_FFFF_FFFF;
        checks++;
        if (r !== exp) begin
          errors++;
          $display("FAIL b2b%0d result %0d: got %h expected %h", which, got, r, exp);
        end
        if (last_ov >= 0) begin
          checks++;
          if (cyc - last_ov !== space) begin
            errors++;
            $display("FAIL b2b%0d spacing %0d: got %0d expected %0d", which, got, cyc - last_ov, space);
          end
        end
        last_ov = cyc;
        got++;
      end
      if (ir && sent < 100) begin
        s32 = $urandom;
        c32 = $urandom;
        if (sent == 0) begin
          s32 = 32'hFFFF_FFFF;
          c32 = 32'hFFFF_FFFF;
        end
        q.push_back({2'b00, s32} + {1'b0, c32, 1'b0});
        sent++;
        if (which) ivb = 1'b1; else iva = 1'b1;
      end else if (ir) begin
        iva = 1'b0;
        ivb = 1'b0;
      end
    end
    iva = 1'b0;
    ivb = 1'b0;
    checks++;
    if (got !== 100) begin
      errors++;
      $display("FAIL b2b%0d timeout: got %0d results expected 100", which, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_reset_mid();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
